mem_bist_initiator: RTL and testbench
=====================================

Name: mem_bist_initiator

Overview:
Autonomous initiator for the team's small switch-addressed register-file memory (4 words x 4 bits, registered read, write when write-select is high). On start it fills every word with a seed-derived pattern, then reads every word back and compares. It reports pass/fail, the mismatch count and the first failing address. It sits in top beside the memory and drives the memory's write-select, address and data inputs in place of SWI, with results routed to LED/SEG.

Parameters:
NWORDS, 4, number of memory words swept (power of two)
ADDR_W, 2, address width, equal to log2(NWORDS)
DATA_W, 4, memory word width

Ports:
clk_2  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a sweep; sampled only in IDLE or DONE
seed  input  DATA_W  pattern seed; captured on the accepted start
mem_we  output  1  memory write-select: 1 = write, 0 = read
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory registered read data, valid the cycle after a read address is presented with mem_we=0
busy  output  1  high while a sweep is in progress
done  output  1  high in DONE, held until the next accepted start
pass  output  1  valid when done=1: 1 if no mismatches
err_count  output  ADDR_W+1  number of mismatching words in the last sweep (0..NWORDS)
fail_addr  output  ADDR_W  address of the first mismatch; 0 if none

Behaviour:
- Reset (reset=0, asynchronous), all outputs held at these values:
  - state=IDLE, busy=0, done=0, pass=0, err_count=0, fail_addr=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal captured seed=0.
- Pattern: pat(a) = (seed_cap + a) mod 2^DATA_W; a is zero-extended and the sum truncated.
- IDLE or DONE with start=1 at an edge:
  - Capture seed; clear err_count and fail_addr.
  - done<=0, busy<=1, go to WRITE with address counter=0.
  - start=0: stay in the current state; outputs unchanged.
- WRITE, one cycle per word:
  - mem_we=1, mem_addr=a, mem_wdata=pat(a) for a=0..NWORDS-1.
  - After a=NWORDS-1, go to READ with address counter=0.
- READ, one cycle per word, pipelined:
  - mem_we=0, mem_addr=a, mem_wdata=0.
  - In the same cycle, compare mem_rdata against pat(a-1) for a>=1; no compare at a=0.
  - After a=NWORDS-1, go to CHECK.
- CHECK, one cycle:
  - mem_we=0; mem_addr holds NWORDS-1.
  - Compare mem_rdata against pat(NWORDS-1).
  - Then go to DONE: busy<=0, done<=1, pass<=(final err_count==0).
- On a mismatch:
  - err_count increments by 1 (maximum NWORDS, so no wrap).
  - If this is the first mismatch of the sweep, fail_addr<=the compared address.
- Sweep timing: busy for exactly 2*NWORDS+1 cycles (9 at default). done asserts on the edge ending CHECK.
- start while busy: ignored; there is no restart mid-sweep.
- start held high: a new sweep is accepted on the first edge in DONE, i.e. back-to-back sweeps with one DONE cycle between them.
- Reset mid-sweep:
  - Immediate return to IDLE and reset values; the memory contents are left partially written.
  - The next start performs a full sweep.
- Address counter wraps naturally at NWORDS; it is only used within each phase.
- pass is meaningful only while done=1; it is forced to 0 while busy.

Test Plan:
- Reset, then idle 5 cycles with start=0 -> all outputs at reset values; mem_we never 1.
- Clean memory model, seed=4'h3, start pulse 1 cycle:
  - Writes observed: addr0=3, addr1=4, addr2=5, addr3=6 on consecutive cycles.
  - busy=1 for 9 cycles; then done=1, pass=1, err_count=0, fail_addr=0.
- seed=4'hE:
  - Patterns wrap to E, F, 0, 1.
  - Readback matches; pass=1.
- Faulty model, bit0 of word 2 stuck at 0, seed=4'h1:
  - Word 2 (pattern 3) reads back as 2.
  - Result: err_count=1, fail_addr=2, pass=0.
- Faulty model, words 1 and 3 forced to 0, seed=4'h0:
  - Word 1 (pattern 1) and word 3 (pattern 3) mismatch.
  - Result: err_count=2, fail_addr=1, pass=0.
- Mid-sweep events:
  - start pulsed again during READ -> ignored; the sweep completes normally.
  - reset asserted during WRITE addr 2 -> outputs immediately at reset values, state IDLE.
  - A fresh start afterwards -> full 9-cycle sweep, pass=1.

Source files
------------

// File: rtl/mem_bist_initiator.sv
// Self-driven write/readback test of the small switch-addressed register-file memory.
// Fills every word with seed+address, reads it back and reports pass, mismatch count and first failing address.
module mem_bist_initiator #(
  parameter int NWORDS = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CHECK,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);
  localparam logic [ADDR_W:0]   MAX_ERR   = (ADDR_W + 1)'(NWORDS);

  state_t            state;
  logic [DATA_W-1:0] seed_cap;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              cmp_en;
  logic              mismatch;

  // Read data lags the address by one cycle, so READ compares the previous word and CHECK picks up the last one.
  always_comb begin
    next_addr = mem_addr + ADDR_W'(1);
    cmp_addr  = (state == CHECK) ? mem_addr : mem_addr - ADDR_W'(1);
    exp_data  = seed_cap + DATA_W'(cmp_addr);
    cmp_en    = ((state == READ) && (mem_addr != '0)) || (state == CHECK);
    mismatch  = cmp_en && (mem_rdata != exp_data);
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      seed_cap  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WRITE;
            seed_cap  <= seed;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= seed;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
          end
        end
        WRITE: begin
          if (mem_addr == LAST_ADDR) begin
            state     <= READ;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            mem_addr  <= next_addr;
            mem_wdata <= seed_cap + DATA_W'(next_addr);
          end
        end
        READ: begin
          if (mem_addr == LAST_ADDR) begin
            state <= CHECK;
          end else begin
            mem_addr <= next_addr;
          end
        end
        CHECK: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0) && !mismatch;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Only the first failing word of a sweep is recorded; the count saturates at the word count.
      if (mismatch) begin
        if (err_count != MAX_ERR) begin
          err_count <= err_count + (ADDR_W + 1)'(1);
        end
        if (err_count == '0) begin
          fail_addr <= cmp_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Directed bench for mem_bist_initiator against a behavioural register-file memory
// whose read path can be made faulty to provoke mismatches.
module tb_mem_bist_initiator;

  logic       clk_2;
  logic       reset;
  logic       start;
  logic [3:0] seed;
  logic       mem_we;
  logic [1:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_addr;

  logic [3:0] mem [4];
  int         fault_mode;
  int         vectors;
  int         miscompares;
  int         busy_cycles;

  mem_bist_initiator #(
    .NWORDS(4),
    .ADDR_W(2),
    .DATA_W(4)
  ) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .start    (start),
    .seed     (seed),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Fault mode 1: word 2 bit 0 stuck at 0; mode 2: words 1 and 3 read as 0.
  function automatic logic [3:0] faultRead(input logic [1:0] a, input logic [3:0] d, input int mode);
    logic [3:0] r;
    r = d;
    if (mode == 1 && a == 2'd2) r[0] = 1'b0;
    if (mode == 2 && (a == 2'd1 || a == 2'd3)) r = 4'h0;
    return r;
  endfunction

  always @(posedge clk_2) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? 4'h0 : faultRead(mem_addr, mem[mem_addr], fault_mode);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'h0);
    checkOutput({tag, "_err"}, 32'(err_count), 32'h0);
    checkOutput({tag, "_fail"}, 32'(fail_addr), 32'h0);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'h0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'h0);
    checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
  endtask

  // Runs one sweep from IDLE/DONE, checking the write phase and counting busy cycles;
  // start is re-pulsed at busy cycle pulse_at (negative means never).
  task automatic applyStimulus(input string tag, input logic [3:0] s, input int pulse_at);
    @(negedge clk_2);
    seed  = s;
    start = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 20) begin
      if (busy_cycles < 4) begin
        checkOutput($sformatf("%s_we%0d", tag, busy_cycles), 32'(mem_we), 32'h1);
        checkOutput($sformatf("%s_addr%0d", tag, busy_cycles), 32'(mem_addr), 32'(busy_cycles));
        checkOutput($sformatf("%s_wdata%0d", tag, busy_cycles), 32'(mem_wdata), 32'(4'(s + 4'(busy_cycles))));
      end else begin
        checkOutput($sformatf("%s_rd_we%0d", tag, busy_cycles), 32'(mem_we), 32'h0);
      end
      start = (busy_cycles == pulse_at);
      @(negedge clk_2);
      start = 1'b0;
      busy_cycles++;
    end
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
    checkOutput({tag, "_done"}, 32'(done), 32'h1);
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'h0);
  endtask

  task automatic checkResult(input string tag, input logic p, input logic [2:0] e, input logic [1:0] f);
    checkOutput({tag, "_pass"}, 32'(pass), 32'(p));
    checkOutput({tag, "_err_count"}, 32'(err_count), 32'(e));
    checkOutput({tag, "_fail_addr"}, 32'(fail_addr), 32'(f));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fault_mode  = 0;
    reset       = 1'b0;
    start       = 1'b0;
    seed        = 4'h0;
    for (int i = 0; i < 4; i++) mem[i] = 4'h0;

    $display("[TB] reset and idle");
    repeat (2) @(negedge clk_2);
    checkResetState("reset");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_2);
      checkOutput($sformatf("idle_we%0d", i), 32'(mem_we), 32'h0);
      checkOutput($sformatf("idle_busy%0d", i), 32'(busy), 32'h0);
    end
    checkResetState("idle");

    $display("[TB] clean sweeps");
    applyStimulus("seed3", 4'h3, -1);
    checkResult("seed3", 1'b1, 3'd0, 2'd0);
    @(negedge clk_2);
    checkOutput("seed3_done_held", 32'(done), 32'h1);
    checkOutput("seed3_mem2", 32'(mem[2]), 32'h5);
    applyStimulus("seedE", 4'hE, -1);
    checkResult("seedE", 1'b1, 3'd0, 2'd0);
    checkOutput("seedE_mem2", 32'(mem[2]), 32'h0);
    checkOutput("seedE_mem3", 32'(mem[3]), 32'h1);

    $display("[TB] faulty memory");
    fault_mode = 1;
    applyStimulus("stuck", 4'h1, -1);
    checkResult("stuck", 1'b0, 3'd1, 2'd2);
    fault_mode = 2;
    applyStimulus("zero13", 4'h0, -1);
    checkResult("zero13", 1'b0, 3'd2, 2'd1);
    fault_mode = 0;

    $display("[TB] start during read");
    applyStimulus("restart", 4'h7, 5);
    checkResult("restart", 1'b1, 3'd0, 2'd0);
    @(negedge clk_2);
    checkOutput("restart_no_rerun", 32'(busy), 32'h0);

    $display("[TB] reset mid-sweep");
    seed  = 4'h9;
    start = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    repeat (2) @(negedge clk_2);
    checkOutput("midrst_addr", 32'(mem_addr), 32'h2);
    checkOutput("midrst_we", 32'(mem_we), 32'h1);
    #2 reset = 1'b0;
    #1;
    checkResetState("midrst");
    @(negedge clk_2);
    checkResetState("midrst_held");
    reset = 1'b1;
    applyStimulus("fresh", 4'h5, -1);
    checkResult("fresh", 1'b1, 3'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
